// File: rtl/text_display_engine.sv
// Text-mode pixel generator: cell RAM + palette + cursor, 3-stage pipeline from
// vga_core timing to RGB, with glyph rows fetched from an external 1-cycle font ROM.
module text_display_engine #(
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 8,
    parameter int HSZ          = 10,
    parameter int VSZ          = 9,
    parameter int CW           = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [HSZ-1:0]                  hcount_i,
    input  logic [VSZ-1:0]                  vcount_i,
    input  logic                            de_i,
    input  logic                            hsync_i,
    input  logic                            vsync_i,
    input  logic                            wr_en_i,
    input  logic [$clog2(COLS*ROWS)-1:0]    wr_addr_i,
    input  logic [15:0]                     wr_data_i,
    input  logic                            reg_we_i,
    input  logic [4:0]                      reg_addr_i,
    input  logic [15:0]                     reg_wdata_i,
    output logic [8+$clog2(CHAR_H)-1:0]     glyph_addr_o,
    input  logic [CHAR_W-1:0]               glyph_data_i,
    output logic [CW-1:0]                   r_o,
    output logic [CW-1:0]                   g_o,
    output logic [CW-1:0]                   b_o,
    output logic                            hsync_o,
    output logic                            vsync_o,
    output logic                            de_o
);
    localparam int NCELL = COLS * ROWS;
    localparam int AW    = $clog2(NCELL);
    localparam int CWB   = $clog2(CHAR_W);
    localparam int CHB   = $clog2(CHAR_H);
    localparam int CLW   = HSZ - CWB;
    localparam int RLW   = VSZ - CHB;
    localparam int PW    = 3 * CW;
    localparam int BW    = $clog2(BLINK_FRAMES + 1);

    logic [15:0]    cell_mem [NCELL];
    logic [PW-1:0]  pal_q [16];
    logic [CLW-1:0] cur_col_q;
    logic [RLW-1:0] cur_row_q;
    logic [1:0]     ctrl_q;
    logic [PW-1:0]  border_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           blink_ph_q;
    logic           vs_prev_q;

    // S1 registers (cell_q is the RAM read port register)
    logic [15:0]    cell_q;
    logic [CWB-1:0] xl1_q;
    logic [CHB-1:0] gr1_q;
    logic           txt1_q, cur1_q, de1_q, hs1_q, vs1_q;
    // S2 registers
    logic [3:0]     fg2_q, bg2_q;
    logic [CWB-1:0] xl2_q;
    logic           txt2_q, cur2_q, de2_q, hs2_q, vs2_q;
    // S3 registers
    logic [PW-1:0]  rgb_q;
    logic           de3_q, hs3_q, vs3_q;

    logic [CLW-1:0] col_d;
    logic [RLW-1:0] row_d;
    logic           in_text_d, cur_hit_d;
    logic [AW-1:0]  rd_addr_d;
    logic           pix_bit_d;
    logic [3:0]     fsel_d, bsel_d;
    logic [PW-1:0]  rgb_d;
    logic           unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    always_comb begin
        col_d     = hcount_i[HSZ-1:CWB];
        row_d     = vcount_i[VSZ-1:CHB];
        in_text_d = ({1'b0, col_d} < (CLW+1)'(COLS)) && ({1'b0, row_d} < (RLW+1)'(ROWS));
        // Out-of-text positions read cell 0; the result is discarded by in_text.
        rd_addr_d = in_text_d ? AW'(row_d) * AW'(COLS) + AW'(col_d) : '0;
        cur_hit_d = in_text_d && ctrl_q[0] && (col_d == cur_col_q) && (row_d == cur_row_q)
                    && (blink_ph_q || !ctrl_q[1]);
    end

    // Cell RAM is not reset; NBA ordering gives read-old-data on a same-cell collision.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && ({1'b0, wr_addr_i} < (AW+1)'(NCELL)))
            cell_mem[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= '0;
            pal_q[0]    <= PW'(12'h008);
            pal_q[15]   <= '1;
            cur_col_q   <= '0;
            cur_row_q   <= '0;
            ctrl_q      <= '0;
            border_q    <= '0;
        end else if (reg_we_i) begin
            case (reg_addr_i)
                5'd16:   cur_col_q <= reg_wdata_i[CLW-1:0];
                5'd17:   cur_row_q <= reg_wdata_i[RLW-1:0];
                5'd18:   ctrl_q    <= reg_wdata_i[1:0];
                5'd19:   border_q  <= reg_wdata_i[PW-1:0];
                default: if (!reg_addr_i[4]) pal_q[reg_addr_i[3:0]] <= reg_wdata_i[PW-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            vs_prev_q <= vsync_i;
            if (vsync_i && !vs_prev_q) begin
                if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q <= '0;
                    blink_ph_q  <= ~blink_ph_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cell_q <= '0;
            xl1_q  <= '0;
            gr1_q  <= '0;
            txt1_q <= 1'b0;
            cur1_q <= 1'b0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
        end else begin
            cell_q <= cell_mem[rd_addr_d];
            xl1_q  <= hcount_i[CWB-1:0];
            gr1_q  <= vcount_i[CHB-1:0];
            txt1_q <= in_text_d;
            cur1_q <= cur_hit_d;
            de1_q  <= de_i;
            hs1_q  <= hsync_i;
            vs1_q  <= vsync_i;
        end
    end

    assign glyph_addr_o = {cell_q[7:0], gr1_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fg2_q  <= '0;
            bg2_q  <= '0;
            xl2_q  <= '0;
            txt2_q <= 1'b0;
            cur2_q <= 1'b0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            fg2_q  <= cell_q[11:8];
            bg2_q  <= cell_q[15:12];
            xl2_q  <= xl1_q;
            txt2_q <= txt1_q;
            cur2_q <= cur1_q;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    // CHAR_W is a power of two, so CHAR_W-1-x is just ~x.
    always_comb begin
        pix_bit_d = glyph_data_i[~xl2_q];
        fsel_d    = cur2_q ? bg2_q : fg2_q;
        bsel_d    = cur2_q ? fg2_q : bg2_q;
        rgb_d     = '0;
        if (de2_q) begin
            if (!txt2_q)        rgb_d = border_q;
            else if (pix_bit_d) rgb_d = pal_q[fsel_d];
            else                rgb_d = pal_q[bsel_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q <= '0;
            de3_q <= 1'b0;
            hs3_q <= 1'b0;
            vs3_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de3_q <= de2_q;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
        end
    end

    assign r_o     = rgb_q[PW-1 -: CW];
    assign g_o     = rgb_q[2*CW-1 -: CW];
    assign b_o     = rgb_q[CW-1:0];
    assign de_o    = de3_q;
    assign hsync_o = hs3_q;
    assign vsync_o = vs3_q;

endmodule

// File: tb/tb_text_display_engine.sv
// Directed bench for text_display_engine: pixel colours, cursor/blink, border,
// sideband delay, reset and cell-write collision, against hand-computed values.
module tb_text_display_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount;
    logic [8:0]  vcount;
    logic        de, hs, vs;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [10:0] glyph_addr;
    logic [7:0]  glyph_data = 8'h00;
    logic [3:0]  r, g, b;
    logic        hs_o, vs_o, de_o;
    logic [11:0] rgb;
    logic [2:0]  hist [40];

    int n_chk  = 0;
    int n_fail = 0;

    assign rgb = {r, g, b};

    text_display_engine #(.BLINK_FRAMES(2)) dut (
        .clk_i(clk), .rst_i(rst), .hcount_i(hcount), .vcount_i(vcount),
        .de_i(de), .hsync_i(hs), .vsync_i(vs),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
        .glyph_addr_o(glyph_addr), .glyph_data_i(glyph_data),
        .r_o(r), .g_o(g), .b_o(b),
        .hsync_o(hs_o), .vsync_o(vs_o), .de_o(de_o)
    );

    always #5 clk = ~clk;

    // Font ROM: 'A' rows all 0x80, 'B' rows all 0xA5, everything else blank.
    function automatic logic [7:0] rom(input logic [10:0] a);
        case (a[10:3])
            8'h41:   return 8'h80;
            8'h42:   return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) glyph_data <= rom(glyph_addr);

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_cell(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 13'(a); wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wr_reg(input int a, input logic [15:0] d);
        reg_we = 1'b1; reg_addr = 5'(a); reg_wdata = d;
        tick(1);
        reg_we = 1'b0;
    endtask

    task automatic pix(input int h, input int v);
        hcount = 10'(h); vcount = 9'(v);
    endtask

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        tick(2);
        check("rst_rgb", rgb, 12'h000);
        check("rst_side", {de_o, hs_o, vs_o}, 3'b000);
        check("rst_gaddr", glyph_addr, 11'h000);
        rst = 1'b0;

        // Basic glyph/palette path
        wr_cell(0, 16'h0F41);
        de = 1'b1;
        pix(0, 0);  tick(3); check("t1_x0", rgb, 12'hFFF);
        pix(1, 0);  tick(3); check("t1_x1", rgb, 12'h008);
        pix(0, 3);  tick(1); check("gaddr_row3", glyph_addr, 11'h20B);
        wr_reg(2, 16'h0123);
        wr_cell(1, 16'h2F42);
        pix(10, 0); tick(3); check("glyphB_x2", rgb, 12'hFFF);
        pix(11, 0); tick(3); check("glyphB_x3", rgb, 12'h123);

        // Cursor, steady mode
        wr_cell(82, 16'h0F41);
        wr_reg(16, 16'd2); wr_reg(17, 16'd1); wr_reg(18, 16'd1);
        pix(16, 8); tick(3); check("cur_x0", rgb, 12'h008);
        pix(17, 8); tick(3); check("cur_x1", rgb, 12'hFFF);
        wr_reg(18, 16'd0);
        pix(16, 8); tick(3); check("cur_off", rgb, 12'hFFF);

        // Border and out-of-range writes/cursor
        wr_reg(19, 16'h00F0);
        pix(640, 0); tick(3); check("border_col", rgb, 12'h0F0);
        pix(0, 480); tick(3); check("border_row", rgb, 12'h0F0);
        wr_reg(16, 16'd80); wr_reg(17, 16'd0); wr_reg(18, 16'd1);
        pix(640, 0); tick(3); check("border_nocur", rgb, 12'h0F0);
        wr_cell(4800, 16'h0000);
        pix(0, 0);   tick(3); check("oob_write", rgb, 12'hFFF);

        // Sideband delay with random de/hsync/vsync
        for (int k = 0; k < 40; k++) begin
            hist[k] = 3'($urandom_range(0, 7));
            {de, hs, vs} = hist[k];
            tick(1);
            if (k >= 2) begin
                check("seq_side", {de_o, hs_o, vs_o}, hist[k-2]);
                check("seq_rgb", rgb, hist[k-2][2] ? 12'hFFF : 12'h000);
            end
        end

        // Palette update reaches output one clock after the write lands
        de = 1'b1; hs = 1'b0; vs = 1'b0;
        pix(0, 0); tick(3);
        wr_reg(15, 16'h0ABC);
        tick(1); check("pal_update", rgb, 12'hABC);

        // Reset mid-line
        hs = 1'b1;
        rst = 1'b1; tick(1);
        check("rst_mid_rgb", rgb, 12'h000);
        check("rst_mid_side", {de_o, hs_o, vs_o}, 3'b000);
        rst = 1'b0;
        tick(2);
        check("rst_lat2_rgb", rgb, 12'h000);
        check("rst_lat2_de", de_o, 1'b0);
        tick(1);
        check("rst_lat3_rgb", rgb, 12'hFFF);
        check("rst_lat3_side", {de_o, hs_o, vs_o}, 3'b110);
        hs = 1'b0;
        pix(1, 0); tick(3); check("pal0_rst", rgb, 12'h008);

        // Blinking cursor, 2 frames per phase
        wr_reg(16, 16'd2); wr_reg(17, 16'd1); wr_reg(18, 16'd3);
        pix(16, 8); tick(3); check("blink_p0", rgb, 12'hFFF);
        for (int i = 1; i <= 4; i++) begin
            vs = 1'b1; tick(1);
            vs = 1'b0; tick(1);
            tick(3);
            check($sformatf("blink_rise%0d", i), rgb, (i == 2 || i == 3) ? 12'h008 : 12'hFFF);
        end

        // Same-cycle write/read of one cell returns old data
        wr_reg(18, 16'd0);
        pix(0, 0); tick(3); check("coll_pre", rgb, 12'hFFF);
        wr_en = 1'b1; wr_addr = 13'd0; wr_data = 16'hF041;
        tick(1);
        wr_en = 1'b0;
        tick(2); check("coll_old", rgb, 12'hFFF);
        tick(1); check("coll_new", rgb, 12'h008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
